// File: rtl/pipelined_cla_subtractor_pkg.sv
// Shared constants and helpers for the pipelined CLA subtractor.
//   SLICE_WIDTH      : bits resolved per pipeline stage
//   sign_pair_t      : operand sign bits travelling with a beat
//   StageCount()     : number of slice stages for a given operand width
//   signed_overflow(): two's-complement overflow rule for A - B
package pipelined_cla_subtractor_pkg;

  localparam int unsigned SLICE_WIDTH = 4;

  typedef struct packed {
    logic a_msb;
    logic b_msb;
  } sign_pair_t;

  function automatic int unsigned StageCount(input int unsigned width);
    return width / SLICE_WIDTH;
  endfunction

  // Difference overflows only when operand signs differ and the result sign
  // disagrees with the minuend.
  function automatic logic signed_overflow(input sign_pair_t s, input logic result_msb);
    return (s.a_msb != s.b_msb) && (result_msb != s.a_msb);
  endfunction

endpackage

// File: rtl/pipelined_cla_subtractor_cla4.sv
// 4-bit carry-lookahead adder slice.
//   InputA, InputB : 4-bit addends
//   InputCarry     : carry-in
//   Output         : 4-bit sum
//   OutputCarry    : carry-out of bit 3
module CarryLookaheadAdder4 (
  input  logic [3:0] InputA,
  input  logic [3:0] InputB,
  input  logic       InputCarry,
  output logic [3:0] Output,
  output logic       OutputCarry
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [4:0] carry;

  assign gen  = InputA & InputB;
  assign prop = InputA ^ InputB;

  // Every carry is expanded directly from generate/propagate terms.
  assign carry[0] = InputCarry;
  assign carry[1] = gen[0] | (prop[0] & carry[0]);
  assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry[0]);
  assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                  | (prop[2] & prop[1] & prop[0] & carry[0]);
  assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                  | (prop[3] & prop[2] & prop[1] & gen[0])
                  | (prop[3] & prop[2] & prop[1] & prop[0] & carry[0]);

  assign Output      = prop ^ carry[3:0];
  assign OutputCarry = carry[4];

endmodule

// File: rtl/pipelined_cla_subtractor.sv
// Pipelined WIDTH-bit subtractor: Output = InputA - InputB - InputBorrow,
// computed as A + ~B + ~InputBorrow, one 4-bit CLA slice per stage.
//   Clock, nReset              : clock, async active-low reset
//   InputValid/InputReady      : operand handshake (InputReady is combinational)
//   InputA, InputB, InputBorrow: minuend, subtrahend, borrow-in
//   OutputValid/OutputReady    : result handshake
//   Output                     : difference modulo 2^WIDTH
//   OutputBorrow               : unsigned borrow-out
//   OutputOverflow             : signed overflow of the difference
module pipelined_cla_subtractor
  import pipelined_cla_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             InputValid,
  output logic             InputReady,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             InputBorrow,
  output logic             OutputValid,
  input  logic             OutputReady,
  output logic [WIDTH-1:0] Output,
  output logic             OutputBorrow,
  output logic             OutputOverflow
);

  localparam int unsigned STAGES = StageCount(WIDTH);

  if ((WIDTH % SLICE_WIDTH) != 0 || WIDTH < SLICE_WIDTH) begin : g_width_check
    $error("pipelined_cla_subtractor: WIDTH must be a non-zero multiple of 4");
  end

  // Level k (0..STAGES-1) feeds slice k. word_q holds finished low result
  // slices below slice k and still-unprocessed minuend slices from slice k up;
  // nb_q holds the inverted subtrahend. Level 0 is the operand capture register.
  logic                                advance;
  logic                                valid_q [STAGES];
  logic [WIDTH-1:0]                    word_q  [STAGES];
  logic [WIDTH-1:0]                    nb_q    [STAGES];
  logic                                carry_q [STAGES];
  sign_pair_t                          sign_q  [STAGES];
  logic [STAGES-1:0][SLICE_WIDTH-1:0]  slice_sum;
  logic [STAGES-1:0]                   slice_cout;
  logic [WIDTH-1:0]                    last_word;

  logic                                out_valid_q;
  logic [WIDTH-1:0]                    out_q;
  logic                                borrow_q;
  logic                                ovf_q;

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance    = !out_valid_q || OutputReady;
  assign InputReady = advance;

  // One CLA slice per stage; the subtrahend is already inverted in nb_q.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    CarryLookaheadAdder4 u_cla (
      .InputA     (word_q[k][SLICE_WIDTH*k +: SLICE_WIDTH]),
      .InputB     (nb_q[k][SLICE_WIDTH*k +: SLICE_WIDTH]),
      .InputCarry (carry_q[k]),
      .Output     (slice_sum[k]),
      .OutputCarry(slice_cout[k])
    );
  end

  // Completed difference at the end of the last slice.
  always_comb begin
    last_word = word_q[STAGES-1];
    last_word[WIDTH-1 -: SLICE_WIDTH] = slice_sum[STAGES-1];
  end

  // Pipeline registers. Data only loads behind a valid beat so outputs keep
  // their last value across bubbles; valid bits always shift on advance.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        word_q[k]  <= '0;
        nb_q[k]    <= '0;
        carry_q[k] <= 1'b0;
        sign_q[k]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_q       <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      valid_q[0] <= InputValid;
      if (InputValid) begin
        word_q[0]       <= InputA;
        nb_q[0]         <= ~InputB;
        carry_q[0]      <= ~InputBorrow;
        sign_q[0].a_msb <= InputA[WIDTH-1];
        sign_q[0].b_msb <= InputB[WIDTH-1];
      end

      for (int unsigned k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          word_q[k]                                  <= word_q[k-1];
          word_q[k][SLICE_WIDTH*(k-1) +: SLICE_WIDTH] <= slice_sum[k-1];
          nb_q[k]                                    <= nb_q[k-1];
          carry_q[k]                                 <= slice_cout[k-1];
          sign_q[k]                                  <= sign_q[k-1];
        end
      end

      out_valid_q <= valid_q[STAGES-1];
      if (valid_q[STAGES-1]) begin
        out_q    <= last_word;
        borrow_q <= ~slice_cout[STAGES-1];
        ovf_q    <= signed_overflow(sign_q[STAGES-1], last_word[WIDTH-1]);
      end
    end
  end

  assign OutputValid    = out_valid_q;
  assign Output         = out_q;
  assign OutputBorrow   = borrow_q;
  assign OutputOverflow = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Self-checking bench for pipelined_cla_subtractor (WIDTH=16, 4 stages).
module tb_pipelined_cla_subtractor;

  localparam int unsigned WIDTH = 16;
  localparam int NRAND = 10000;

  logic             Clock;
  logic             nReset;
  logic             InputValid;
  logic             InputReady;
  logic [WIDTH-1:0] InputA;
  logic [WIDTH-1:0] InputB;
  logic             InputBorrow;
  logic             OutputValid;
  logic             OutputReady;
  logic [WIDTH-1:0] Output;
  logic             OutputBorrow;
  logic             OutputOverflow;

  int errors = 0;
  int checks = 0;

  pipelined_cla_subtractor #(.WIDTH(WIDTH)) dut (
    .Clock         (Clock),
    .nReset        (nReset),
    .InputValid    (InputValid),
    .InputReady    (InputReady),
    .InputA        (InputA),
    .InputB        (InputB),
    .InputBorrow   (InputBorrow),
    .OutputValid   (OutputValid),
    .OutputReady   (OutputReady),
    .Output        (Output),
    .OutputBorrow  (OutputBorrow),
    .OutputOverflow(OutputOverflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] out;
    logic        borrow;
    logic        ovf;
  } vec_t;

  vec_t vecs [12];
  logic [17:0] sb [$];
  logic [17:0] stream_exp [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reference: {borrow, overflow, difference} from plain wide arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] t;
    logic        ovf;
    t   = {1'b0, a} - {1'b0, b} - 17'(bin);
    ovf = (a[15] != b[15]) && (t[15] != a[15]);
    return {t[16], ovf, t[15:0]};
  endfunction

  task automatic send_one(input vec_t v, input string tag);
    int lat;
    bit got;
    InputA = v.a; InputB = v.b; InputBorrow = v.bin;
    InputValid = 1'b1; OutputReady = 1'b1;
    #1;
    check({tag, " ready"}, 32'(InputReady), 32'd1);
    tick();
    InputValid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (OutputValid) got = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " out"}, 32'(Output), 32'(v.out));
    check({tag, " borrow"}, 32'(OutputBorrow), 32'(v.borrow));
    check({tag, " ovf"}, 32'(OutputOverflow), 32'(v.ovf));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int recv;
    int beats;
    int cyc;

    vecs[0]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[1]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[2]  = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[9]  = '{16'h0F0F, 16'hF0F0, 1'b0, 16'h1E1F, 1'b1, 1'b0};
    vecs[10] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0};

    // Reset held with a valid beat presented.
    nReset = 1'b0; InputValid = 1'b1; InputA = 16'h1111; InputB = 16'h0000;
    InputBorrow = 1'b0; OutputReady = 1'b1;
    repeat (3) tick();
    check("reset valid", 32'(OutputValid), 32'd0);
    check("reset out", 32'(Output), 32'd0);
    check("reset borrow", 32'(OutputBorrow), 32'd0);
    check("reset ovf", 32'(OutputOverflow), 32'd0);
    nReset = 1'b1; InputValid = 1'b0;
    #1;
    check("ready after release", 32'(InputReady), 32'd1);
    beats = 0;
    repeat (10) begin tick(); if (OutputValid) beats++; end
    check("no beat after reset", 32'(beats), 32'd0);

    // Directed single beats with latency check.
    for (int i = 0; i < 12; i++) send_one(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream with a 3-cycle output stall.
    for (int i = 0; i < 8; i++) stream_exp[i] = model(16'(i * 'h1111), 16'h0101, 1'b0);
    sent = 0; recv = 0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      OutputReady = !(c >= 6 && c < 9);
      InputValid  = (sent < 8);
      InputA      = 16'(sent * 'h1111);
      InputB      = 16'h0101;
      InputBorrow = 1'b0;
      #1;
      check($sformatf("stream ready c%0d", c), 32'(InputReady), (c >= 6 && c < 9) ? 32'd0 : 32'd1);
      if (!OutputReady) begin
        check($sformatf("stall valid c%0d", c), 32'(OutputValid), 32'd1);
        check($sformatf("stall hold c%0d", c), 32'({OutputBorrow, OutputOverflow, Output}),
              32'(stream_exp[recv]));
      end
      if (OutputValid && OutputReady) begin
        check($sformatf("stream beat %0d", recv), 32'({OutputBorrow, OutputOverflow, Output}),
              32'(stream_exp[recv]));
        recv++;
      end
      if (InputValid && InputReady) sent++;
      tick();
    end
    check("stream count", 32'(recv), 32'd8);
    InputValid = 1'b0; OutputReady = 1'b1;
    beats = 0;
    repeat (8) begin tick(); if (OutputValid) beats++; end
    check("stream no extra", 32'(beats), 32'd0);

    // Reset with beats in flight and one waiting at the output.
    InputValid = 1'b1; InputA = 16'h4444; InputB = 16'h0001; InputBorrow = 1'b0;
    OutputReady = 1'b0;
    repeat (8) tick();
    check("flush prefill valid", 32'(OutputValid), 32'd1);
    #1 nReset = 1'b0;
    #1 check("flush async drop", 32'(OutputValid), 32'd0);
    @(posedge Clock);
    @(posedge Clock);
    #1;
    nReset = 1'b1; InputValid = 1'b0; OutputReady = 1'b1;
    beats = 0;
    repeat (10) begin tick(); if (OutputValid) beats++; end
    check("flush no stale", 32'(beats), 32'd0);
    send_one(vecs[1], "post flush");

    // Random valid/ready against the scoreboard.
    sent = 0; recv = 0; cyc = 0;
    sb.delete();
    while (recv < NRAND && cyc < 60000) begin
      OutputReady = ($urandom_range(3, 0) != 0);
      InputValid  = (sent < NRAND) && ($urandom_range(3, 0) != 0);
      InputA      = 16'($urandom);
      InputB      = 16'($urandom);
      InputBorrow = 1'($urandom);
      #1;
      if (OutputValid && OutputReady) begin
        if (sb.size() == 0) check("rand spurious beat", 32'd1, 32'd0);
        else check($sformatf("rand beat %0d", recv), 32'({OutputBorrow, OutputOverflow, Output}),
                   32'(sb.pop_front()));
        recv++;
      end
      if (InputValid && InputReady) begin
        sb.push_back(model(InputA, InputB, InputBorrow));
        sent++;
      end
      tick();
      cyc++;
    end
    check("rand all beats", 32'(recv), 32'(NRAND));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
